// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program image as a byte stream and writes it into the pipeline CPU's
//   instruction memory. The CPU is held in reset until the whole image has been written
//   and its XOR checksum has been verified.
//
//   Stream: 2-byte word count N (MSB first), N big-endian 32-bit words, 1 checksum byte
//   equal to the XOR of every preceding byte.
//
// Ports
//   CLK           in   clock, all state changes on the rising edge
//   Reset         in   asynchronous active-high reset
//   byteData      in   [7:0] stream byte
//   byteValid     in   byteData is valid
//   byteReady     out  a byte can be accepted this cycle
//   imemWrite     out  instruction-memory write strobe, one cycle per word
//   imemAddress   out  [31:0] byte address of the word being written
//   imemWriteData out  [31:0] instruction word
//   cpuReset      out  reset to the CPU core, high until the load succeeds
//   loadDone      out  image loaded and checksum matched
//   loadError     out  oversize header or checksum mismatch
//   wordCount     out  [15:0] words written so far
module imem_boot_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  byteData,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        imemWrite,
    output logic [31:0] imemAddress,
    output logic [31:0] imemWriteData,
    output logic        cpuReset,
    output logic        loadDone,
    output logic        loadError,
    output logic [15:0] wordCount
);

    typedef enum logic [2:0] {
        HdrHi,
        HdrLo,
        Load,
        Check,
        Done,
        Error
    } loaderState;

    loaderState  state;
    logic [7:0]  headerHi;
    logic [15:0] numWords;
    logic [1:0]  byteCount;
    logic [23:0] assembler;
    logic [7:0]  checksum;

    logic        accept;
    logic [15:0] headerWord;
    logic [15:0] nextCount;

    always_comb begin
        byteReady = 1'b0;
        if (!Reset) begin
            case (state)
                HdrHi, HdrLo, Load, Check: byteReady = 1'b1;
                default:                   byteReady = 1'b0;
            endcase
        end
    end

    assign accept     = byteValid & byteReady;
    assign headerWord = {headerHi, byteData};
    assign nextCount  = wordCount + 16'd1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= HdrHi;
            headerHi      <= 8'h00;
            numWords      <= 16'h0000;
            byteCount     <= 2'd0;
            assembler     <= 24'h000000;
            checksum      <= 8'h00;
            imemWrite     <= 1'b0;
            imemAddress   <= ADDR_BASE;
            imemWriteData <= 32'h0000_0000;
            cpuReset      <= 1'b1;
            loadDone      <= 1'b0;
            loadError     <= 1'b0;
            wordCount     <= 16'h0000;
        end else begin
            imemWrite <= 1'b0;
            if (accept) begin
                // The checksum byte itself is folded in too; the compare below uses the
                // value accumulated over the preceding bytes.
                checksum <= checksum ^ byteData;
                case (state)
                    HdrHi: begin
                        headerHi <= byteData;
                        state    <= HdrLo;
                    end
                    HdrLo: begin
                        numWords <= headerWord;
                        if (32'(headerWord) > MAX_WORDS) begin
                            state     <= Error;
                            loadError <= 1'b1;
                        end else if (headerWord == 16'h0000) begin
                            state <= Check;
                        end else begin
                            state <= Load;
                        end
                    end
                    Load: begin
                        byteCount <= byteCount + 2'd1;
                        if (byteCount == 2'd3) begin
                            imemWrite     <= 1'b1;
                            imemWriteData <= {assembler, byteData};
                            // Address of word k = base + 4k, wrapping at 32 bits.
                            imemAddress   <= ADDR_BASE + {14'd0, wordCount, 2'b00};
                            wordCount     <= nextCount;
                            // Leaving Load here is what keeps wordCount saturated at N.
                            if (nextCount == numWords) begin
                                state <= Check;
                            end
                        end else begin
                            assembler <= {assembler[15:0], byteData};
                        end
                    end
                    Check: begin
                        if (checksum == byteData) begin
                            state    <= Done;
                            loadDone <= 1'b1;
                            cpuReset <= 1'b0;
                        end else begin
                            state     <= Error;
                            loadError <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader. Two instances share one byte stream: one with default
// parameters and one with a non-zero base and a small word limit. A reference model turns
// each stream into expected writes and final status; a negedge monitor checks writes.
module tb_imem_boot_loader;

    typedef logic [7:0] byteT;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } writeT;

    localparam logic [31:0] BASE1 = 32'h0000_0100;
    localparam int MAX1 = 3;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  byteData = 8'h00;
    logic        byteValid = 1'b0;
    logic [1:0]  readyV, writeV, cpuResetV, doneV, errV;
    logic [31:0] addr0, addr1, data0, data1;
    logic [15:0] wc0, wc1;

    int nCompared = 0;
    int nMismatched = 0;

    byteT  stream[$];
    writeT q0[$];
    writeT q1[$];
    bit [1:0] expDone, expErr;
    int    expCount[2];

    logic willAccept = 1'b0;
    int   cyc = 0;
    int   lastAccCyc = -1;

    imem_boot_loader u0 (
        .CLK(CLK), .Reset(Reset), .byteData(byteData), .byteValid(byteValid),
        .byteReady(readyV[0]), .imemWrite(writeV[0]), .imemAddress(addr0),
        .imemWriteData(data0), .cpuReset(cpuResetV[0]), .loadDone(doneV[0]),
        .loadError(errV[0]), .wordCount(wc0)
    );

    imem_boot_loader #(.ADDR_BASE(BASE1), .MAX_WORDS(MAX1)) u1 (
        .CLK(CLK), .Reset(Reset), .byteData(byteData), .byteValid(byteValid),
        .byteReady(readyV[1]), .imemWrite(writeV[1]), .imemAddress(addr1),
        .imemWriteData(data1), .cpuReset(cpuResetV[1]), .loadDone(doneV[1]),
        .loadError(errV[1]), .wordCount(wc1)
    );

    always #5 CLK = ~CLK;

    // Edge counter and the edge at which the last byte was accepted.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (willAccept) lastAccCyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue and must
    // appear in the cycle right after the edge that accepted the word's last byte.
    always @(negedge CLK) begin
        writeT w;
        if (writeV[0] === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpectedWrite0", addr0, 32'hxxxx_xxxx);
            end else begin
                w = q0.pop_front();
                check("writeAddr0", addr0, w.addr);
                check("writeData0", data0, w.data);
                check("writeCycle0", cyc, lastAccCyc);
            end
        end
        if (writeV[1] === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpectedWrite1", addr1, 32'hxxxx_xxxx);
            end else begin
                w = q1.pop_front();
                check("writeAddr1", addr1, w.addr);
                check("writeData1", data1, w.data);
                check("writeCycle1", cyc, lastAccCyc);
            end
        end
    end

    // Reference model: from the first len bytes of the stream, derive the writes and the
    // final status of a loader with the given base and word limit.
    task automatic modelStream(input int idx, input logic [31:0] base, input int maxW,
                               input int len);
        int n;
        int k;
        logic [7:0] x;
        writeT w;
        expDone[idx] = 1'b0;
        expErr[idx] = 1'b0;
        expCount[idx] = 0;
        if (len < 2) return;
        n = int'({stream[0], stream[1]});
        if (n > maxW) begin
            expErr[idx] = 1'b1;
            return;
        end
        for (k = 0; k < n; k++) begin
            if (2 + 4 * k + 4 > len) break;
            w.addr = base + 32'(4 * k);
            w.data = {stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]};
            if (idx == 0) q0.push_back(w);
            else q1.push_back(w);
            expCount[idx] = k + 1;
        end
        if (len > 2 + 4 * n) begin
            x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stream[i];
            if (x == stream[2+4*n]) expDone[idx] = 1'b1;
            else expErr[idx] = 1'b1;
        end
    endtask

    task automatic makeStream(input int n, input bit goodCs);
        logic [7:0] cs;
        logic [31:0] w;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[15:8]);
        stream.push_back(n16[7:0]);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            stream.push_back(w[31:24]);
            stream.push_back(w[23:16]);
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
        cs = 8'h00;
        foreach (stream[i]) cs = cs ^ stream[i];
        if (!goodCs) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        stream.push_back(cs);
    endtask

    // Offers len bytes, each for one cycle, with random idle gaps. Called and returns at a
    // negedge; on return the last offered byte's edge has just passed.
    task automatic sendStream(input int len, input int stallPct);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 99) < stallPct) begin
                byteValid = 1'b0;
                willAccept = 1'b0;
                @(negedge CLK);
            end
            byteValid = 1'b1;
            byteData = stream[i];
            willAccept = readyV[0];
            @(negedge CLK);
        end
        byteValid = 1'b0;
        willAccept = 1'b0;
    endtask

    task automatic checkStatus(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.loadDone%0d", tag, i), 32'(doneV[i]), 32'(expDone[i]));
            check($sformatf("%s.loadError%0d", tag, i), 32'(errV[i]), 32'(expErr[i]));
            check($sformatf("%s.cpuReset%0d", tag, i), 32'(cpuResetV[i]), 32'(!expDone[i]));
            check($sformatf("%s.byteReady%0d", tag, i), 32'(readyV[i]),
                  32'(!(expDone[i] || expErr[i])));
        end
        check({tag, ".wordCount0"}, 32'(wc0), 32'(expCount[0]));
        check({tag, ".wordCount1"}, 32'(wc1), 32'(expCount[1]));
    endtask

    task automatic runFull(input string tag, input int stallPct);
        modelStream(0, 32'h0, 1024, stream.size());
        modelStream(1, BASE1, MAX1, stream.size());
        sendStream(stream.size(), stallPct);
        checkStatus({tag, ".edge"});
        repeat (3) @(negedge CLK);
        checkStatus({tag, ".hold"});
    endtask

    // Asserts Reset between clock edges and checks the asynchronous reset values, then
    // releases it at a negedge.
    task automatic doReset();
        @(posedge CLK);
        check("pendingWrites0", 32'(q0.size()), 0);
        check("pendingWrites1", 32'(q1.size()), 0);
        q0.delete();
        q1.delete();
        #3;
        Reset = 1'b1;
        byteValid = 1'b0;
        willAccept = 1'b0;
        #1;
        check("rst.cpuReset", 32'(cpuResetV), 32'h3);
        check("rst.imemWrite", 32'(writeV), 32'h0);
        check("rst.loadDone", 32'(doneV), 32'h0);
        check("rst.loadError", 32'(errV), 32'h0);
        check("rst.byteReady", 32'(readyV), 32'h0);
        check("rst.addr0", addr0, 32'h0);
        check("rst.addr1", addr1, BASE1);
        check("rst.data0", data0, 32'h0);
        check("rst.data1", data1, 32'h0);
        check("rst.wordCount", {wc1, wc0}, 32'h0);
        @(negedge CLK);
        check("rst.byteReadyHeld", 32'(readyV), 32'h0);
        Reset = 1'b0;
        #1;
        check("rst.byteReadyRelease", 32'(readyV), 32'h3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        doReset();

        // Two-word example stream, no stalls, then again with random stalls.
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] cs;
            stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
            cs = 8'h00;
            foreach (stream[i]) cs = cs ^ stream[i];
            stream.push_back(cs);
            runFull(pass == 0 ? "fixed" : "fixedStall", pass == 0 ? 0 : 50);
            doReset();
        end

        // Empty image with good and bad checksum.
        stream = '{8'h00, 8'h00, 8'h00};
        runFull("emptyGood", 0);
        doReset();
        stream = '{8'h00, 8'h00, 8'hFF};
        runFull("emptyBad", 0);
        doReset();

        // Oversize header; later bytes must be ignored.
        stream = '{8'h04, 8'h01, 8'h12, 8'h34, 8'h56};
        runFull("oversize", 0);
        doReset();

        // Reset after six bytes of a three-word load, then a clean one-word load.
        makeStream(3, 1'b1);
        modelStream(0, 32'h0, 1024, 6);
        modelStream(1, BASE1, MAX1, 6);
        sendStream(6, 0);
        repeat (2) @(negedge CLK);
        doReset();
        makeStream(1, 1'b1);
        runFull("afterAbort", 30);
        doReset();

        // Randomised images, including counts at and above the small instance's limit.
        for (int t = 0; t < 20; t++) begin
            makeStream($urandom_range(0, 5), $urandom_range(0, 3) != 0);
            runFull($sformatf("rand%0d", t), $urandom_range(0, 60));
            doReset();
        end

        // Largest accepted image, no stalls.
        makeStream(1024, 1'b1);
        runFull("maxWords", 0);
        doReset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot loader that receives a program as a byte stream and writes it into the pipeline CPU's instruction memory. It holds the CPU in reset until the program image has been loaded and its checksum has been verified. It sits between an external byte source (a host link or test stimulus) and the instruction-memory write port. Its `cpuReset` output drives the CPU core's `Reset`.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h0000_0000: byte address of the first instruction word.
- `MAX_WORDS`, default 1024: largest accepted word count. A header above this value is an error.

Ports:
- `CLK`  input  1: single clock. All state changes on the rising edge.
- `Reset`  input  1: asynchronous, active-high reset.
- `byteData`  input  8: incoming stream byte.
- `byteValid`  input  1: `byteData` is valid.
- `byteReady`  output  1: the block can accept a byte.
- `imemWrite`  output  1: instruction-memory write strobe, one cycle per word.
- `imemAddress`  output  32: byte address of the word being written.
- `imemWriteData`  output  32: instruction word.
- `cpuReset`  output  1: reset to the CPU core. High until the load succeeds.
- `loadDone`  output  1: image loaded and checksum matched.
- `loadError`  output  1: oversize header or checksum mismatch.
- `wordCount`  output  16: number of words written so far.

## Operation
Stream format, in order:
- 2-byte word count N, MSB first.
- N words, 4 bytes each, big-endian. The first byte goes to bits [31:24].
- 1 checksum byte, equal to the XOR of every preceding byte, header included.

A byte transfers on a rising edge when `byteValid` and `byteReady` are both high. Every transferred byte is XORed into a running checksum register.

States:
- HDR_HI: accept the high byte of N, then go to HDR_LO.
- HDR_LO: accept the low byte of N. Then:
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CHECK.
  - otherwise: go to LOAD.
- LOAD: shift bytes into a 32-bit assembler, tracking position with a 2-bit byte counter. On the 4th byte:
  - latch the word and issue a write;
  - increment `wordCount`;
  - when `wordCount` reaches N, go to CHECK.
- CHECK: accept the checksum byte.
  - Match (running XOR == received byte): go to DONE.
  - Mismatch: go to ERROR.
- DONE: `loadDone`=1, `cpuReset`=0, `byteReady`=0. Stays here until `Reset`.
- ERROR: `loadError`=1, `cpuReset`=1, `byteReady`=0. Stays here until `Reset`.

Output rules:
- `byteReady` = 0 while `Reset` is high. Otherwise it is 1 in HDR_HI, HDR_LO, LOAD and CHECK.
- Write address for word k is ADDR_BASE + 4·k, with k counted from 0. The 32-bit addition wraps modulo 2^32.
- Bytes offered with `byteValid` while `byteReady` is low are ignored and have no effect on the checksum.

## Timing
Reset values, asserted asynchronously:
- state = HDR_HI
- `cpuReset`=1, `imemWrite`=0, `imemAddress`=ADDR_BASE, `imemWriteData`=0
- `loadDone`=0, `loadError`=0, `wordCount`=0
- checksum = 0, byte counter = 0

Cycle-level behaviour:
- `imemWrite` is registered. It is high for exactly the one cycle after the edge that accepts the 4th byte of a word. `imemAddress` and `imemWriteData` are valid during that cycle and hold until the next write.
- Back-to-back bytes are accepted every cycle with no bubbles. The minimum spacing between writes is 4 cycles.
- On a checksum match, `cpuReset` falls and `loadDone` rises on the same edge that accepts the checksum byte.
- `loadError` rises on the edge that accepts the offending byte.
- Full load latency with no stalls: the checksum is accepted on edge 3+4N after the first byte edge, counting the first byte edge as edge 1.
- Reset mid-load returns the block to HDR_HI immediately and sets `cpuReset`=1. Partial words are discarded. Words already written to memory are not erased.
- Stalls (`byteValid` low) can occur at any byte position. They freeze all state. No timeout exists.
- `wordCount` saturates at N. It cannot exceed MAX_WORDS.

## Test plan
- Reset asserted mid-cycle → all outputs at their reset values immediately. `byteReady`=0 while `Reset`=1 and becomes 1 after release.
- Stream 00 02 | 24 08 00 05 | AC 08 00 00 | checksum (XOR of all preceding bytes) → two write pulses:
  - addr 0x0, data 0x24080005;
  - addr 0x4, data 0xAC080000;
  - then `loadDone`=1 and `cpuReset`=0 on the checksum edge.
- Same stream with `byteValid` toggled randomly and ADDR_BASE = 0x100 → identical data at addresses 0x100 and 0x104, with no extra or dropped writes.
- Stream 00 00 00 (N=0, checksum 0x00) → no writes and `loadDone`=1. Stream 00 00 FF instead → `loadError`=1 and `cpuReset` stays 1.
- Header 04 01 with MAX_WORDS=1024 → `loadError`=1 on the HDR_LO edge, `byteReady`=0 afterwards, no writes.
- Reset asserted after 6 bytes of a 3-word load, then a full valid 1-word stream → exactly one write, at ADDR_BASE, then `loadDone`=1 and `wordCount`=1.
